// File: rtl/mobo_mem_ctrl.sv
// Motherboard memory controller: word-addressed RAM behind a 4-phase
// request/done handshake with a fixed BUSY latency before completion.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mobo_mem_ctrl #(
  parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] mobo_ctrl,
  input  logic [WORD_WIDTH-1:0] mobo_addr,
  input  logic [WORD_WIDTH-1:0] mobo_wdata,
  output logic [WORD_WIDTH-1:0] mobo_stat,
  output logic [WORD_WIDTH-1:0] mobo_rdata
);
  localparam int unsigned         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_WIDTH:0] DEPTH_W  = (WORD_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]          CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  op_wr, op_wr_nx;
  logic [WORD_WIDTH-1:0] addr_q, addr_nx;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_nx;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_nx;
  logic                  busy, busy_nx, done, done_nx, err, err_nx;
  logic                  ram_we;
  logic [WORD_WIDTH-1:0] ram [DEPTH];

  logic          rd_req, wr_req, in_range;
  logic [AW-1:0] ram_idx;
  logic          unused_ctrl;

  assign rd_req      = mobo_ctrl[0];
  assign wr_req      = mobo_ctrl[1];
  assign unused_ctrl = ^mobo_ctrl[WORD_WIDTH-1:2];
  // Full-width compare: no address wrap into the RAM for out-of-range requests
  assign in_range    = {1'b0, addr_q} < DEPTH_W;
  assign ram_idx     = addr_q[AW-1:0];

  assign mobo_stat  = WORD_WIDTH'({err, done, busy});
  assign mobo_rdata = rdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_wr_nx = op_wr;
    addr_nx  = addr_q;
    wdata_nx = wdata_q;
    rdata_nx = rdata_q;
    busy_nx  = busy;
    done_nx  = done;
    err_nx   = err;
    ram_we   = 1'b0;
    case (state)
      IDLE: begin
        busy_nx = 1'b0;
        done_nx = 1'b0;
        err_nx  = 1'b0;
        if (rd_req ^ wr_req) begin
          op_wr_nx = wr_req;
          addr_nx  = mobo_addr;
          wdata_nx = mobo_wdata;
          cnt_nx   = CNT_INIT;
          busy_nx  = 1'b1;
          state_nx = WAIT;
        end else if (rd_req && wr_req) begin
          done_nx  = 1'b1;
          err_nx   = 1'b1;
          state_nx = DONE;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nx = cnt - 4'd1;
        end else begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = DONE;
          if (!in_range)  err_nx   = 1'b1;
          else if (op_wr) ram_we   = 1'b1;
          else            rdata_nx = ram[ram_idx];
        end
      end
      DONE: begin
        if (!rd_req && !wr_req) begin
          done_nx  = 1'b0;
          err_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      op_wr   <= op_wr_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      rdata_q <= rdata_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      err     <= err_nx;
    end
  end

  // RAM is not reset; a write completing on a reset edge is dropped
  always_ff @(posedge clk) begin
    if (rst && ram_we) ram[ram_idx] <= wdata_q;
  end
endmodule

// File: tb/tb_mobo_mem_ctrl.sv
// Scoreboard bench for mobo_mem_ctrl: driver pushes expected completions,
// a monitor pops and compares them whenever DONE rises.
module tb_mobo_mem_ctrl;
  localparam int W     = 16;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  localparam logic [W-1:0] ST_IDLE = 16'h0;
  localparam logic [W-1:0] ST_BUSY = 16'h1;
  localparam logic [W-1:0] ST_DONE = 16'h2;
  localparam logic [W-1:0] ST_ERR  = 16'h6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] ctrl, addr, wdata, stat, rdata;
  logic [W-1:0] ctrl1, addr1, wdata1, stat1, rdata1;

  mobo_mem_ctrl #(.WORD_WIDTH(W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mobo_ctrl(ctrl), .mobo_addr(addr),
    .mobo_wdata(wdata), .mobo_stat(stat), .mobo_rdata(rdata)
  );

  mobo_mem_ctrl #(.WORD_WIDTH(W), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mobo_ctrl(ctrl1), .mobo_addr(addr1),
    .mobo_wdata(wdata1), .mobo_stat(stat1), .mobo_rdata(rdata1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] stat;
    logic [W-1:0] rdata;
    int           busy;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] mem_m [DEPTH];
  logic [W-1:0] rdata_m = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares a completion each time DONE rises
  initial begin : monitor
    int   busy_cnt;
    logic prev_done;
    exp_t e;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy_cnt  = 0;
        prev_done = 1'b0;
      end else begin
        if (stat[0]) busy_cnt++;
        if (stat[1] && !prev_done) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got stat %h want no completion", stat);
          end else begin
            e = sbq.pop_front();
            check("done_stat", stat, e.stat);
            check("done_rdata", rdata, e.rdata);
            check("busy_cycles", W'(busy_cnt), W'(e.busy));
          end
          busy_cnt = 0;
        end
        prev_done = stat[1];
      end
    end
  end

  // Issue one transaction, wait for completion, hold the request, release
  task automatic do_txn(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] d, input int hold);
    exp_t         e;
    logic [W-1:0] c;
    int           n;
    if (op == 2'b11) begin
      e.stat = ST_ERR; e.busy = 0;
    end else if (int'(a) >= DEPTH) begin
      e.stat = ST_ERR; e.busy = LAT;
    end else begin
      e.stat = ST_DONE; e.busy = LAT;
      if (op == 2'b10) mem_m[a[7:0]] = d;
      else             rdata_m = mem_m[a[7:0]];
    end
    e.rdata = rdata_m;
    sbq.push_back(e);

    c      = W'($urandom);
    c[1:0] = op;
    ctrl   = c;
    addr   = a;
    wdata  = d;
    n      = 0;
    do begin
      @(negedge clk);
      n++;
      addr  = W'($urandom);
      wdata = W'($urandom);
    end while (!stat[1] && n < 40);
    if (!stat[1]) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got stat %h want DONE within 40 cycles", stat);
    end else begin
      for (int i = 0; i < hold; i++) begin
        ctrl[1:0] = 2'($urandom_range(1, 3));
        @(negedge clk);
        check("hold_stat", stat, e.stat);
      end
    end
    c      = W'($urandom);
    c[1:0] = 2'b00;
    ctrl   = c;
    @(negedge clk);
    check("release_stat", stat, ST_IDLE);
  endtask

  task automatic lat1_txn(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] d, input logic [W-1:0] exp_rd);
    ctrl1  = W'(op);
    addr1  = a;
    wdata1 = d;
    @(negedge clk);
    check("lat1_busy", stat1, ST_BUSY);
    @(negedge clk);
    check("lat1_done", stat1, ST_DONE);
    check("lat1_rdata", rdata1, exp_rd);
    ctrl1 = '0;
    @(negedge clk);
    check("lat1_release", stat1, ST_IDLE);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int           kind;
    logic [W-1:0] a, d;
    ctrl = '0; addr = '0; wdata = '0;
    ctrl1 = '0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    check("reset_stat", stat, ST_IDLE);
    check("reset_rdata", rdata, '0);
    check("reset_stat1", stat1, ST_IDLE);
    rst = 1'b1;
    @(negedge clk);

    lat1_txn(2'b10, 16'd0, 16'h000F, 16'h0000);
    lat1_txn(2'b01, 16'd0, 16'h0000, 16'h000F);

    for (int i = 0; i < DEPTH; i++) do_txn(2'b10, W'(i), W'($urandom), 0);

    do_txn(2'b10, 16'd5,   16'hA5A5, 0);
    do_txn(2'b01, 16'd5,   16'h0000, 1);
    do_txn(2'b01, 16'd256, 16'h0000, 0);
    do_txn(2'b10, 16'd300, 16'hDEAD, 0);
    do_txn(2'b01, 16'd44,  16'h0000, 0);
    do_txn(2'b11, 16'd44,  16'hBEEF, 2);
    do_txn(2'b01, 16'd44,  16'h0000, 10);
    do_txn(2'b01, 16'hFFFF, 16'h0000, 0);

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      d    = W'($urandom);
      if (kind <= 6) a = W'($urandom_range(0, DEPTH - 1));
      else           a = W'($urandom_range(DEPTH, 65535));
      if (kind <= 3 || kind == 7)      do_txn(2'b01, a, d, int'($urandom_range(0, 3)));
      else if (kind == 9)              do_txn(2'b11, a, d, int'($urandom_range(0, 3)));
      else                             do_txn(2'b10, a, d, int'($urandom_range(0, 3)));
    end

    // Reset landing on the completion edge of a write must drop the write
    do_txn(2'b10, 16'd7, 16'h5A5A, 0);
    ctrl  = 16'h0002;
    addr  = 16'd7;
    wdata = 16'h1234;
    @(negedge clk);
    check("rst_busy", stat, ST_BUSY);
    repeat (LAT - 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ctrl    = '0;
    rdata_m = '0;
    check("rst_mid_stat", stat, ST_IDLE);
    check("rst_mid_rdata", rdata, '0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_stat", stat, ST_IDLE);
    do_txn(2'b01, 16'd7, 16'h0000, 0);

    repeat (5) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
